// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a single-outstanding valid/ready request
// channel, programmable wait states and a registered response channel.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic          accept, enter_resp, rsp_done;
    logic          cur_write, cur_error, mem_we;
    logic [31:0]   cur_addr, cur_wdata, rd_word;
    logic [3:0]    cur_wstrb;
    logic [AW-1:0] cur_idx;

    always_comb begin
        accept   = (state_q == S_IDLE) && req_valid && req_ready_q;
        rsp_done = (state_q == S_RESP) && rsp_ready;

        // With no wait states the response resolves on the acceptance edge,
        // so the live request fields are used instead of the latched copy.
        if (WAIT_CYCLES == 0) begin
            cur_write  = req_write;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
            cur_wstrb  = req_wstrb;
            enter_resp = accept;
        end else begin
            cur_write  = write_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
            cur_wstrb  = wstrb_q;
            enter_resp = (state_q == S_WAIT) && (cnt_q <= 4'd1);
        end

        cur_error = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DEPTH_LIM);
        cur_idx   = cur_addr[AW+1:2];
        mem_we    = enter_resp && cur_write && !cur_error;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    cnt_d       = WAIT_INIT;
                    req_ready_d = 1'b0;
                    state_d     = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_done) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = cur_error;
            rsp_rdata_d = (!cur_write && !cur_error) ? rd_word : 32'h0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    // One byte-wide array per lane keeps strobed writes free of read-modify-write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];

        always_ff @(posedge clock) begin
            if (mem_we && cur_wstrb[gi]) begin
                lane_mem[cur_idx] <= cur_wdata[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = lane_mem[cur_idx];
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 1 and 3 wait states) share
// one stimulus stream and are checked every cycle against a cycle-count model.
module tb_data_mem_responder;
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 1;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;

    logic        vin [3];
    logic        rdy [3];
    logic        vld [3];
    logic [31:0] rd  [3];
    logic        er  [3];
    logic        o_rdy, o_vld, o_er;
    logic [31:0] o_rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        assign vin[gi] = req_valid && (sel == gi);
        data_mem_responder #(
            .DEPTH_WORDS(DW),
            .WAIT_CYCLES((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
        ) u_dut (
            .clock    (clk),
            .reset    (rst_n),
            .req_valid(vin[gi]),
            .req_ready(rdy[gi]),
            .req_write(req_write),
            .req_addr (req_addr),
            .req_wdata(req_wdata),
            .req_wstrb(req_wstrb),
            .rsp_valid(vld[gi]),
            .rsp_ready(rsp_ready),
            .rsp_rdata(rd[gi]),
            .rsp_error(er[gi])
        );
    end

    assign o_rdy = rdy[sel];
    assign o_vld = vld[sel];
    assign o_rd  = rd[sel];
    assign o_er  = er[sel];

    function automatic int wc(input int s);
        return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for the DUT (t=%0t)", nm, $time);
    endtask

    // ---------------- behavioural model (edge-count based) ----------------
    int          edge_n = 0;
    bit          m_busy = 0, m_fresh = 0, m_pend = 0, m_exp_er = 0;
    int          m_acc = 0, acc_cnt = 0, done_cnt = 0, last_acc = 0, prev_acc = 0;
    logic [31:0] m_exp_rd = '0, m_pd = '0;
    logic [3:0]  m_ps = '0, m_pidx = '0;
    logic [31:0] mmem [3][DW];
    int          m_w;
    bit          m_was_busy;

    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            m_busy  = 0;
            m_pend  = 0;
            m_fresh = 1;
        end else begin
            m_w = wc(sel);
            m_was_busy = m_busy;
            if (m_busy && (edge_n - 1) >= m_acc + m_w && rsp_ready) begin
                m_busy = 0;
                done_cnt++;
            end else if (!m_was_busy && !m_fresh && req_valid) begin
                m_busy   = 1;
                m_acc    = edge_n;
                prev_acc = last_acc;
                last_acc = edge_n;
                acc_cnt++;
                m_exp_er = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DW));
                m_pidx   = req_addr[5:2];
                m_exp_rd = (!m_exp_er && !req_write) ? mmem[sel][m_pidx] : 32'h0;
                if (!m_exp_er && req_write) begin
                    m_pend = 1;
                    m_pd   = req_wdata;
                    m_ps   = req_wstrb;
                end
            end
            m_fresh = 0;
            if (m_pend && edge_n == m_acc + m_w) begin
                for (int b = 0; b < 4; b++)
                    if (m_ps[b]) mmem[sel][m_pidx][8*b +: 8] = m_pd[8*b +: 8];
                m_pend = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] last_rd = '0;
    logic        last_er = 1'b0;

    always @(negedge clk) begin
        logic        e_rdy, e_vld, e_er;
        logic [31:0] e_rd;
        e_rdy = 1'b0; e_vld = 1'b0; e_er = 1'b0; e_rd = 32'h0;
        if (rst_n && !m_fresh) begin
            if (!m_busy) begin
                e_rdy = 1'b1;
            end else if (edge_n >= m_acc + wc(sel)) begin
                e_vld = 1'b1;
                e_rd  = m_exp_rd;
                e_er  = m_exp_er;
                last_rd = o_rd;
                last_er = o_er;
            end
        end
        chk("req_ready", {31'b0, o_rdy}, {31'b0, e_rdy});
        chk("rsp_valid", {31'b0, o_vld}, {31'b0, e_vld});
        chk("rsp_rdata", o_rd, e_rd);
        chk("rsp_error", {31'b0, o_er}, {31'b0, e_er});
    end

    // ---------------- stimulus ----------------
    task automatic txn(input int s, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st, input int hold,
                       output logic [31:0] r_rd, output logic r_er);
        int a0, d0, k;
        sel = s;
        req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
        req_valid = 1'b1; rsp_ready = 1'b0;
        a0 = acc_cnt; k = 0;
        while (acc_cnt == a0 && k < 50) begin @(posedge clk); #2; k++; end
        req_valid = 1'b0;
        if (acc_cnt == a0) begin
            tmo("accept");
            r_rd = 'x; r_er = 1'bx;
            return;
        end
        req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        d0 = done_cnt; k = 0;
        while (done_cnt == d0 && k < 100) begin
            rsp_ready = (k >= hold) ? ($urandom_range(0, 3) != 0) : 1'b0;
            @(posedge clk); #2; k++;
        end
        rsp_ready = 1'b0;
        if (done_cnt == d0) tmo("response");
        r_rd = last_rd; r_er = last_er;
        $display("txn inst=%0d %s addr=%h wd=%h st=%h -> rd=%h err=%0d",
                 s, wr ? "ST" : "LD", addr, wd, st, r_rd, r_er);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          a0, k;

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        for (int s = 0; s < 3; s++)
            for (int i = 0; i < DW; i++)
                txn(s, 1, 32'(i * 4), $urandom, 4'hF, 0, r, e);

        // Full-word store then load, one wait state.
        txn(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, r, e);
        chk("t1_store_err", {31'b0, e}, 32'h0);
        txn(1, 0, 32'h10, 32'h0, 4'h0, 0, r, e);
        chk("t1_load_data", r, 32'hDEADBEEF);
        chk("t1_load_err", {31'b0, e}, 32'h0);

        // Byte strobes.
        txn(1, 1, 32'h20, 32'h11223344, 4'hF, 0, r, e);
        txn(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, r, e);
        chk("t2_store_rdata", r, 32'h0);
        txn(1, 0, 32'h20, 32'h0, 4'h0, 0, r, e);
        chk("t2_load_data", r, 32'h11BB33DD);

        // Errors, zero-strobe store, aliasing of out-of-range onto word 0.
        txn(1, 1, 32'h0, 32'hCAFEF00D, 4'hF, 0, r, e);
        txn(1, 0, 32'h22, 32'h0, 4'h0, 0, r, e);
        chk("t3_misaligned_err", {31'b0, e}, 32'h1);
        chk("t3_misaligned_rdata", r, 32'h0);
        txn(1, 1, 32'(DW * 4), 32'hFFFFFFFF, 4'hF, 0, r, e);
        chk("t3_range_err", {31'b0, e}, 32'h1);
        txn(1, 1, 32'h0, 32'h12121212, 4'h0, 0, r, e);
        chk("t3_nostrobe_err", {31'b0, e}, 32'h0);
        txn(1, 0, 32'h0, 32'h0, 4'h0, 0, r, e);
        chk("t3_word0_kept", r, 32'hCAFEF00D);

        // Response backpressure held well past the response.
        txn(1, 0, 32'h10, 32'h0, 4'h0, 7, r, e);
        chk("t4_backpressure_data", r, 32'hDEADBEEF);

        // Reset during WAIT drops an uncommitted store (3 wait states).
        txn(2, 1, 32'h8, 32'h12345678, 4'hF, 0, r, e);
        sel = 2; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h55; req_wstrb = 4'hF;
        req_valid = 1'b1;
        a0 = acc_cnt; k = 0;
        while (acc_cnt == a0 && k < 50) begin @(posedge clk); #2; k++; end
        if (acc_cnt == a0) tmo("t5_accept");
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req_ready", {31'b0, rdy[2]}, 32'h0);
        chk("t5_rst_rsp_valid", {31'b0, vld[2]}, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        $display("txn inst=2 ST addr=00000008 wd=00000055 dropped by reset");
        txn(2, 0, 32'h8, 32'h0, 4'h0, 0, r, e);
        chk("t5_old_value", r, 32'h12345678);

        // Zero wait states: back-to-back loads with rsp_ready tied high.
        for (int i = 0; i < 4; i++) txn(0, 1, 32'(i * 4), 32'hA0A0A000 + 32'(i), 4'hF, 0, r, e);
        sel = 0; rsp_ready = 1'b1; req_write = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'(i * 4);
            a0 = acc_cnt; k = 0;
            while (acc_cnt == a0 && k < 20) begin @(posedge clk); #2; k++; end
            if (acc_cnt == a0) tmo("t6_accept");
            else if (i > 0) chk("t6_spacing", 32'(last_acc - prev_acc), 32'd2);
            $display("txn inst=0 LD addr=%h back-to-back", 32'(i * 4));
        end
        req_valid = 1'b0;
        k = 0;
        while (m_busy && k < 20) begin @(posedge clk); #2; k++; end
        if (m_busy) tmo("t6_drain");
        rsp_ready = 1'b0;
        txn(0, 0, 32'hC, 32'h0, 4'h0, 0, r, e);
        chk("t6_load_data", r, 32'hA0A0A003);

        // Randomized traffic across all three instances.
        for (int n = 0; n < 300; n++) begin
            int          s, kind;
            logic [31:0] a;
            s = $urandom_range(0, 2);
            kind = $urandom_range(0, 7);
            if (kind == 0)      a = 32'($urandom_range(0, DW - 1) * 4 + $urandom_range(1, 3));
            else if (kind == 1) a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(DW, DW + 8) * 4) : ($urandom | 32'h8000_0000);
            else                a = 32'($urandom_range(0, DW - 1) * 4);
            txn(s, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), r, e);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
